// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 set-2 scan-code decoder: FSM states,
// prefix and modifier codes, and the set of bytes that carry no key event.
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_e;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    // Pause prefix, self-test/ack/echo/resend replies and error bytes.
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [7:0] b);
        return (b == CODE_LSHIFT) || (b == CODE_RSHIFT);
    endfunction

endpackage

// File: rtl/scancode2ascii.sv
// Combinational set-2 scan code to ASCII lookup; letters and the digit row
// honour shift, everything unmapped returns 0x00.
module scancode2ascii (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic [7:0] digit;
    logic [7:0] digit_shifted;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        letter        = 8'h00;
        digit         = 8'h00;
        digit_shifted = 8'h00;
        ascii         = 8'h00;

        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase

        case (code)
            8'h16: begin digit = "1"; digit_shifted = "!"; end
            8'h1E: begin digit = "2"; digit_shifted = "@"; end
            8'h26: begin digit = "3"; digit_shifted = "#"; end
            8'h25: begin digit = "4"; digit_shifted = "$"; end
            8'h2E: begin digit = "5"; digit_shifted = "%"; end
            8'h36: begin digit = "6"; digit_shifted = "^"; end
            8'h3D: begin digit = "7"; digit_shifted = "&"; end
            8'h3E: begin digit = "8"; digit_shifted = "*"; end
            8'h46: begin digit = "9"; digit_shifted = "("; end
            8'h45: begin digit = "0"; digit_shifted = ")"; end
            default: begin digit = 8'h00; digit_shifted = 8'h00; end
        endcase

        if (letter != 8'h00) begin
            ascii = shift ? (letter - 8'h20) : letter;
        end else if (digit != 8'h00) begin
            ascii = shift ? digit_shifted : digit;
        end else if (code == 8'h29) begin
            ascii = 8'h20;
        end else if (code == 8'h5A) begin
            ascii = 8'h0D;
        end
    end

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 byte stream decoder: strips E0/F0 prefixes, emits make/break
// events, tracks the held key, shift state and a count of distinct presses.
module kbd_scan_decoder
    import kbd_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               evt_valid,
    output logic               evt_break,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic [7:0]         key_ascii,
    output logic               key_held,
    output logic [COUNT_W-1:0] key_count
);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               evt_valid_q, evt_valid_d;
    logic               evt_break_q, evt_break_d;
    logic [7:0]         key_code_q, key_code_d;
    logic               key_ext_q, key_ext_d;
    logic [7:0]         key_ascii_q, key_ascii_d;
    logic               key_held_q, key_held_d;
    logic [8:0]         held_key_q, held_key_d;
    logic [COUNT_W-1:0] key_count_q, key_count_d;
    logic               shift_q, shift_d;

    logic       accept;
    logic       commit;
    logic       commit_ext;
    logic       commit_brk;
    logic [7:0] lut_ascii;

    // Lookup runs on the incoming byte so ascii lands together with key_code.
    scancode2ascii u_lut (
        .code  (in_data),
        .shift (shift_q),
        .ascii (lut_ascii)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = !accept;
        evt_valid_d = 1'b0;
        evt_break_d = evt_break_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_ascii_d = key_ascii_q;
        key_held_d  = key_held_q;
        held_key_d  = held_key_q;
        key_count_d = key_count_q;
        shift_d     = shift_q;
        commit      = 1'b0;
        commit_ext  = 1'b0;
        commit_brk  = 1'b0;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == CODE_EXT)      state_d = ST_EXT;
                    else if (in_data == CODE_BRK) state_d = ST_BRK;
                    else if (!is_ignored(in_data)) commit = 1'b1;
                end
                ST_EXT: begin
                    if (in_data == CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        commit     = 1'b1;
                        commit_ext = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    commit     = 1'b1;
                    commit_brk = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    commit     = 1'b1;
                    commit_ext = 1'b1;
                    commit_brk = 1'b1;
                    state_d    = ST_IDLE;
                end
            endcase
        end

        if (commit) begin
            evt_valid_d = 1'b1;
            evt_break_d = commit_brk;
            key_code_d  = in_data;
            key_ext_d   = commit_ext;
            key_ascii_d = commit_ext ? 8'h00 : lut_ascii;
            if (!commit_brk) begin
                // Typematic repeats of the held key do not count as new presses.
                if (!key_held_q || held_key_q != {commit_ext, in_data})
                    key_count_d = key_count_q + COUNT_W'(1);
                key_held_d = 1'b1;
                held_key_d = {commit_ext, in_data};
                if (!commit_ext && is_shift(in_data)) shift_d = 1'b1;
            end else begin
                if (key_held_q && held_key_q == {commit_ext, in_data}) key_held_d = 1'b0;
                if (!commit_ext && is_shift(in_data)) shift_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_break_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_ascii_q <= 8'h00;
            key_held_q  <= 1'b0;
            held_key_q  <= 9'h000;
            key_count_q <= '0;
            shift_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            evt_valid_q <= evt_valid_d;
            evt_break_q <= evt_break_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_ascii_q <= key_ascii_d;
            key_held_q  <= key_held_d;
            held_key_q  <= held_key_d;
            key_count_q <= key_count_d;
            shift_q     <= shift_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign evt_valid = evt_valid_q;
    assign evt_break = evt_break_q;
    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_ascii = key_ascii_q;
    assign key_held  = key_held_q;
    assign key_count = key_count_q;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Scoreboard bench: a reference model pushes expected events as bytes are
// driven; a negedge monitor pops and compares whenever evt_valid pulses.
module tb_kbd_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;

    logic       in_ready, evt_valid, evt_break, key_ext, key_held;
    logic [7:0] key_code, key_ascii, key_count;
    logic       w2_in_ready, w2_evt_valid, w2_evt_break, w2_key_ext, w2_key_held;
    logic [7:0] w2_key_code, w2_key_ascii;
    logic [1:0] w2_key_count;

    always #5 clk = ~clk;

    kbd_scan_decoder dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .evt_valid(evt_valid), .evt_break(evt_break),
        .key_code(key_code), .key_ext(key_ext), .key_ascii(key_ascii),
        .key_held(key_held), .key_count(key_count)
    );

    kbd_scan_decoder #(.COUNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(w2_in_ready), .evt_valid(w2_evt_valid), .evt_break(w2_evt_break),
        .key_code(w2_key_code), .key_ext(w2_key_ext), .key_ascii(w2_key_ascii),
        .key_held(w2_key_held), .key_count(w2_key_count)
    );

    typedef struct {
        logic       brk;
        logic [7:0] code;
        logic       ext;
        logic [7:0] ascii;
        logic       held;
        int         count;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_state = 0;
    logic       m_held  = 1'b0;
    logic [8:0] m_hkey  = 9'h0;
    int         m_count = 0;
    logic       m_shift = 1'b0;
    logic [7:0] m_code  = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic sh);
        case (c)
            8'h1C: return sh ? 8'h41 : 8'h61;
            8'h32: return sh ? 8'h42 : 8'h62;
            8'h21: return sh ? 8'h43 : 8'h63;
            8'h23: return sh ? 8'h44 : 8'h64;
            8'h24: return sh ? 8'h45 : 8'h65;
            8'h16: return sh ? 8'h21 : 8'h31;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_commit(input logic [7:0] b, input logic ext, input logic brk);
        exp_t e;
        e.brk   = brk;
        e.code  = b;
        e.ext   = ext;
        e.ascii = ext ? 8'h00 : ref_ascii(b, m_shift);
        if (!brk) begin
            if (!m_held || m_hkey != {ext, b}) m_count++;
            m_held = 1'b1;
            m_hkey = {ext, b};
            if (!ext && (b == 8'h12 || b == 8'h59)) m_shift = 1'b1;
        end else begin
            if (m_held && m_hkey == {ext, b}) m_held = 1'b0;
            if (!ext && (b == 8'h12 || b == 8'h59)) m_shift = 1'b0;
        end
        m_code  = b;
        e.held  = m_held;
        e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_state)
            0: begin
                if (b == 8'hE0)      m_state = 1;
                else if (b == 8'hF0) m_state = 2;
                else if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}))
                    model_commit(b, 1'b0, 1'b0);
            end
            1: begin
                if (b == 8'hF0) m_state = 3;
                else begin model_commit(b, 1'b1, 1'b0); m_state = 0; end
            end
            2: begin model_commit(b, 1'b0, 1'b1); m_state = 0; end
            default: begin model_commit(b, 1'b1, 1'b1); m_state = 0; end
        endcase
    endtask

    task automatic model_reset();
        m_state = 0;
        m_held  = 1'b0;
        m_hkey  = 9'h0;
        m_count = 0;
        m_shift = 1'b0;
        m_code  = 8'h00;
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge
    // with in_valid still high so back-to-back calls stream bytes.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("ready_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
        end else begin
            model_byte(b);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
        idle(2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (evt_valid === 1'b1) begin
            check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("evt_break", 32'(evt_break), 32'(e.brk));
                check("key_code",  32'(key_code),  32'(e.code));
                check("key_ext",   32'(key_ext),   32'(e.ext));
                check("key_ascii", 32'(key_ascii), 32'(e.ascii));
                check("key_held",  32'(key_held),  32'(e.held));
                check("key_count", 32'(key_count), 32'(e.count % 256));
                check("w2_key_count", 32'(w2_key_count), 32'(e.count % 4));
            end
        end
    end

    initial begin
        logic [7:0] pattern;
        int         xfers;

        #12;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_key_code",  32'(key_code),  32'd0);
        check("rst_key_ascii", 32'(key_ascii), 32'd0);
        check("rst_key_held",  32'(key_held),  32'd0);
        check("rst_key_count", 32'(key_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Press and release 'a'
        send_seq('{8'h1C, 8'hF0, 8'h1C});
        // Typematic repeats then release
        send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
        // Shifted letter
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        // Shifted digit via right shift, then unshifted letter
        send_seq('{8'h59, 8'h16, 8'hF0, 8'h16, 8'hF0, 8'h59, 8'h32, 8'hF0, 8'h32});

        // Extended key: prefix must leave key_code alone
        send_byte(8'hE0);
        check("prefix_keeps_code", 32'(key_code), 32'(m_code));
        check("prefix_no_evt", 32'(evt_valid), 32'd0);
        send_seq('{8'h75});
        check("ext_held", 32'(key_held), 32'd1);
        send_seq('{8'hE0, 8'hF0, 8'h75});
        check("ext_released", 32'(key_held), 32'd0);

        // Ignored replies in IDLE produce nothing
        send_seq('{8'hAA, 8'hFA, 8'h00, 8'hFF});
        check("ignored_count", 32'(key_count), 32'(m_count % 256));

        // Non-matching break keeps the held key
        send_seq('{8'h21, 8'hF0, 8'h23});
        check("nonmatch_break_held", 32'(key_held), 32'd1);
        send_seq('{8'hF0, 8'h21});

        // Streaming: in_valid held high across four bytes
        xfers = 0;
        pattern = 8'h00;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    #1;
                    pattern[i] = in_ready;
                    if (in_valid && in_ready) xfers++;
                    @(negedge clk);
                end
            end
            begin
                send_byte(8'h1C);
                send_byte(8'hF0);
                send_byte(8'h1C);
                send_byte(8'h32);
            end
        join
        idle(2);
        check("stream_ready_pattern", 32'(pattern), 32'h55);
        check("stream_xfers", 32'(xfers), 32'd4);
        send_seq('{8'hF0, 8'h32});

        // Reset in the middle of an extended sequence
        send_byte(8'hE0);
        idle(1);
        rst = 1'b1;
        model_reset();
        #2;
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_key_count", 32'(key_count), 32'd0);
        check("midrst_key_ext",   32'(key_ext),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_seq('{8'h75});
        check("post_rst_ext", 32'(key_ext), 32'd0);
        check("post_rst_code", 32'(key_code), 32'h75);

        // Five distinct presses since reset: narrow counter wraps to 1
        send_seq('{8'h1C, 8'h32, 8'h21, 8'h23});
        check("wrap_w2_count", 32'(w2_key_count), 32'd1);
        check("wrap_count", 32'(key_count), 32'd5);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
